// File: rtl/navig_ctrl_pkg.sv
// Shared types and constants for the navigation ping-cycle sequencer.
// NAVIG_WATCHDOG_EN (see navig_cycle_ctrl) uses WDOG_CYCLES from here.
package navig_ctrl_pkg;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_ARM     = 3'd1,
    ST_FIRE    = 3'd2,
    ST_TX_WAIT = 3'd3,
    ST_GUARD   = 3'd4,
    ST_LISTEN  = 3'd5,
    ST_DONE    = 3'd6
  } navig_state_e;

  // Interrupt cause codes read by the HPS driver
  localparam logic [7:0] CAUSE_NONE    = 8'h00;
  localparam logic [7:0] CAUSE_RX      = 8'h01;
  localparam logic [7:0] CAUSE_TIMEOUT = 8'h02;
  localparam logic [7:0] CAUSE_ABORT   = 8'h03;
  localparam logic [7:0] CAUSE_TX_HANG = 8'h04;

  // TX watchdog length in cycles (2^20)
  localparam int unsigned WDOG_CYCLES = 32'd1048576;

  // busy is low in DONE so that it falls in the same cycle irq rises
  function automatic logic busy_in(input navig_state_e s);
    logic b;
    case (s)
      ST_IDLE, ST_DONE: b = 1'b0;
      default:          b = 1'b1;
    endcase
    return b;
  endfunction

endpackage

// File: rtl/navig_interval_counter.sv
// Loadable, saturating down-counter shared by the guard, listen and
// watchdog phases. zero is decoded from the count register.
module navig_interval_counter #(
  parameter int CNT_W = 32
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             load,
  input  logic [CNT_W-1:0] load_val,
  input  logic             en,
  output logic             zero
);

  logic [CNT_W-1:0] count_r;

  // Load wins over decrement; decrement stops at zero instead of wrapping
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      count_r <= {CNT_W{1'b0}};
    end else if (load) begin
      count_r <= load_val;
    end else if (en && (count_r != {CNT_W{1'b0}})) begin
      count_r <= count_r - {{(CNT_W-1){1'b0}}, 1'b1};
    end else begin
      count_r <= count_r;
    end
  end

  assign zero = (count_r == {CNT_W{1'b0}});

endmodule

// File: rtl/navig_cycle_ctrl.sv
// Navigation ping-cycle sequencer: arm, fire TX, wait for TX, blank RX for
// the guard interval, listen for RX bytes or timeout, then raise irq.
// Optional TX_WAIT watchdog compiled in with `define NAVIG_WATCHDOG_EN.
module navig_cycle_ctrl
  import navig_ctrl_pkg::*;
#(
  parameter int CNT_W  = 32,
  parameter int FIFO_W = 8
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              go,
  input  logic              abort,
  input  logic [FIFO_W-1:0] size_fifo_tx,
  input  logic              ready_tx,
  output logic              start_tx,
  output logic              navig_timer_start,
  input  logic [CNT_W-1:0]  guard_interval,
  input  logic [CNT_W-1:0]  listen_timeout,
  input  logic [FIFO_W-1:0] size_fifo_rx,
  input  logic [FIFO_W-1:0] rx_min_bytes,
  output logic              irq,
  input  logic              irq_ack,
  output logic [7:0]        irq_cause,
  output logic              busy
);

  navig_state_e      state_r, next_state_s;
  logic [CNT_W-1:0]  guard_r, timeout_r, listen_load_s, cnt_val_s;
  logic [FIFO_W-1:0] rx_min_r;
  logic              seen_low_r, cnt_load_s, cnt_en_s, cnt_zero_s, irq_set_s;
  logic              start_tx_r, timer_start_r, irq_r, busy_r;
  logic [7:0]        irq_cause_r, cause_next_s;

  // The listen window is exactly timeout cycles, so the entry load is one
  // less (the entry cycle itself counts); zero stays zero.
  assign listen_load_s = (timeout_r == {CNT_W{1'b0}}) ? {CNT_W{1'b0}}
                       : (timeout_r - {{(CNT_W-1){1'b0}}, 1'b1});

  navig_interval_counter #(.CNT_W(CNT_W)) u_cnt (
    .clk      (clk),
    .reset_n  (reset_n),
    .load     (cnt_load_s),
    .load_val (cnt_val_s),
    .en       (cnt_en_s),
    .zero     (cnt_zero_s)
  );

  // Next-state, counter control and interrupt request decode
  always_comb begin
    next_state_s = state_r;
    cnt_load_s   = 1'b0;
    cnt_val_s    = {CNT_W{1'b0}};
    cnt_en_s     = 1'b0;
    irq_set_s    = 1'b0;
    cause_next_s = irq_cause_r;
    case (state_r)
      ST_IDLE: begin
        if (go && !irq_r) begin
          next_state_s = ST_ARM;
        end else begin
          next_state_s = ST_IDLE;
        end
      end
      ST_ARM: begin
        if ((size_fifo_tx != {FIFO_W{1'b0}}) && ready_tx) begin
          next_state_s = ST_FIRE;
        end else begin
          next_state_s = ST_ARM;
        end
      end
      ST_FIRE: begin
        next_state_s = ST_TX_WAIT;
`ifdef NAVIG_WATCHDOG_EN
        cnt_load_s = 1'b1;
        cnt_val_s  = CNT_W'(WDOG_CYCLES);
`endif
      end
      ST_TX_WAIT: begin
        // ready_tx must have been seen low before its return counts
        if (seen_low_r && ready_tx) begin
          next_state_s = ST_GUARD;
          cnt_load_s   = 1'b1;
          cnt_val_s    = guard_r;
        end
`ifdef NAVIG_WATCHDOG_EN
        else if (cnt_zero_s) begin
          next_state_s = ST_IDLE;
          irq_set_s    = 1'b1;
          cause_next_s = CAUSE_TX_HANG;
        end else begin
          cnt_en_s = 1'b1;
        end
`else
        else begin
          next_state_s = ST_TX_WAIT;
        end
`endif
      end
      ST_GUARD: begin
        // RX levels are deliberately ignored while blanking
        if (cnt_zero_s) begin
          next_state_s = ST_LISTEN;
          cnt_load_s   = 1'b1;
          cnt_val_s    = listen_load_s;
        end else begin
          cnt_en_s = 1'b1;
        end
      end
      ST_LISTEN: begin
        if (size_fifo_rx >= rx_min_r) begin
          next_state_s = ST_DONE;
          irq_set_s    = 1'b1;
          cause_next_s = CAUSE_RX;
        end else if (cnt_zero_s) begin
          next_state_s = ST_DONE;
          irq_set_s    = 1'b1;
          cause_next_s = CAUSE_TIMEOUT;
        end else begin
          cnt_en_s = 1'b1;
        end
      end
      ST_DONE: begin
        next_state_s = ST_IDLE;
      end
      default: begin
        next_state_s = ST_IDLE;
      end
    endcase
    if (abort && (state_r != ST_IDLE)) begin
      next_state_s = ST_IDLE;
      irq_set_s    = 1'b1;
      cause_next_s = CAUSE_ABORT;
      cnt_load_s   = 1'b0;
      cnt_en_s     = 1'b0;
    end else begin
      cause_next_s = cause_next_s;
    end
  end

  // State register
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_r <= ST_IDLE;
    end else begin
      state_r <= next_state_s;
    end
  end

  // Cycle parameters are captured when go is accepted
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      guard_r   <= {CNT_W{1'b0}};
      timeout_r <= {CNT_W{1'b0}};
      rx_min_r  <= {FIFO_W{1'b0}};
    end else if ((state_r == ST_IDLE) && go && !irq_r) begin
      guard_r   <= guard_interval;
      timeout_r <= listen_timeout;
      rx_min_r  <= rx_min_bytes;
    end else begin
      guard_r   <= guard_r;
      timeout_r <= timeout_r;
      rx_min_r  <= rx_min_r;
    end
  end

  // Remembers that the transmitter went busy after the start pulse
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      seen_low_r <= 1'b0;
    end else if (state_r == ST_FIRE) begin
      seen_low_r <= 1'b0;
    end else if ((state_r == ST_TX_WAIT) && !ready_tx) begin
      seen_low_r <= 1'b1;
    end else begin
      seen_low_r <= seen_low_r;
    end
  end

  // Registered outputs decoded from the next state; a new irq beats irq_ack
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      start_tx_r    <= 1'b0;
      timer_start_r <= 1'b0;
      busy_r        <= 1'b0;
      irq_r         <= 1'b0;
      irq_cause_r   <= CAUSE_NONE;
    end else begin
      start_tx_r    <= (next_state_s == ST_FIRE);
      timer_start_r <= (next_state_s == ST_FIRE);
      busy_r        <= busy_in(next_state_s);
      if (irq_set_s) begin
        irq_r       <= 1'b1;
        irq_cause_r <= cause_next_s;
      end else if (irq_ack) begin
        irq_r       <= 1'b0;
        irq_cause_r <= irq_cause_r;
      end else begin
        irq_r       <= irq_r;
        irq_cause_r <= irq_cause_r;
      end
    end
  end

  assign start_tx          = start_tx_r;
  assign navig_timer_start = timer_start_r;
  assign busy              = busy_r;
  assign irq               = irq_r;
  assign irq_cause         = irq_cause_r;

endmodule

// File: tb/tb_navig_cycle_ctrl.sv
// Bench for navig_cycle_ctrl: per-cycle expectation tables filled from the
// cycle rules, one compare process, plus literal irq-timing pins.
module tb_navig_cycle_ctrl;

  localparam int CNT_W  = 32;
  localparam int FIFO_W = 8;
  localparam int MAXC   = 1024;

  logic              clk = 1'b0;
  logic              reset_n = 1'b0;
  logic              go = 1'b0;
  logic              abort = 1'b0;
  logic              ready_tx = 1'b0;
  logic              irq_ack = 1'b0;
  logic [FIFO_W-1:0] size_fifo_tx = 8'd0;
  logic [FIFO_W-1:0] size_fifo_rx = 8'd0;
  logic [FIFO_W-1:0] rx_min_bytes = 8'd0;
  logic [CNT_W-1:0]  guard_interval = 32'd0;
  logic [CNT_W-1:0]  listen_timeout = 32'd0;
  logic              start_tx, navig_timer_start, irq, busy;
  logic [7:0]        irq_cause;

  int        cyc = 0;
  int        checks = 0;
  int        errors = 0;
  int        rises = 0;
  int        exp_rises = 0;
  int        pin_rise = -1;
  logic [7:0] pin_cause = 8'h00;
  bit        end_req = 1'b0;
  bit        end_done = 1'b0;
  bit        prev_irq = 1'b0;

  bit         exp_busy  [MAXC];
  bit         exp_irq   [MAXC];
  bit         exp_start [MAXC];
  logic [7:0] exp_cause [MAXC];

  navig_cycle_ctrl #(.CNT_W(CNT_W), .FIFO_W(FIFO_W)) dut (
    .clk               (clk),
    .reset_n           (reset_n),
    .go                (go),
    .abort             (abort),
    .size_fifo_tx      (size_fifo_tx),
    .ready_tx          (ready_tx),
    .start_tx          (start_tx),
    .navig_timer_start (navig_timer_start),
    .guard_interval    (guard_interval),
    .listen_timeout    (listen_timeout),
    .size_fifo_rx      (size_fifo_rx),
    .rx_min_bytes      (rx_min_bytes),
    .irq               (irq),
    .irq_ack           (irq_ack),
    .irq_cause         (irq_cause),
    .busy              (busy)
  );

  always #5 clk = ~clk;

  // Cycle index: cycle k starts at the k-th rising edge
  always @(posedge clk) cyc <= cyc + 1;

  task automatic cmp(input string nm, input int act, input int req);
    checks++;
    if (act != req) begin
      errors++;
      $display("FAIL %s cycle %0d: got %0d expected %0d", nm, cyc, act, req);
    end
  endtask

  // Single compare process: reset values, per-cycle tables, irq pins
  initial begin : compare_proc
    forever begin
      @(negedge clk or negedge reset_n);
      #1;
      if (!reset_n) begin
        cmp("rst_start_tx", start_tx, 0);
        cmp("rst_timer_start", navig_timer_start, 0);
        cmp("rst_busy", busy, 0);
        cmp("rst_irq", irq, 0);
        cmp("rst_irq_cause", irq_cause, 0);
        prev_irq = 1'b0;
      end else begin
        if (cyc < MAXC) begin
          cmp("busy", busy, exp_busy[cyc]);
          cmp("irq", irq, exp_irq[cyc]);
          cmp("irq_cause", irq_cause, exp_cause[cyc]);
          cmp("start_tx", start_tx, exp_start[cyc]);
          cmp("timer_start", navig_timer_start, exp_start[cyc]);
        end
        if (irq && !prev_irq) begin
          rises++;
          cmp("irq_rise_cycle", cyc, pin_rise);
          cmp("irq_rise_cause", irq_cause, pin_cause);
        end
        prev_irq = irq;
        if (end_req && !end_done) begin
          cmp("irq_rise_count", rises, exp_rises);
          end_done = 1'b1;
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_irq_from(input int a, input logic [7:0] c);
    for (int i = a; i < MAXC; i++) begin
      exp_irq[i]   = 1'b1;
      exp_cause[i] = c;
    end
  endtask

  task automatic clr_irq_from(input int a);
    for (int i = a; i < MAXC; i++) exp_irq[i] = 1'b0;
  endtask

  task automatic clear_from(input int a);
    for (int i = a; i < MAXC; i++) begin
      exp_busy[i]  = 1'b0;
      exp_irq[i]   = 1'b0;
      exp_start[i] = 1'b0;
      exp_cause[i] = 8'h00;
    end
  endtask

  // One full cycle started now: TX busy for 5 cycles starting 4 cycles
  // after go, RX level rxv from LISTEN-relative cycle rx_rel onwards.
  // pin_off/pin_c are the hand-computed irq rise offset and cause.
  task automatic do_cycle(input int g, input int t, input int rmin,
                          input int rx_rel, input int rxv,
                          input int pin_off, input logic [7:0] pin_c);
    int n, d, r, l, e, k, win;
    logic [7:0] c;
    n   = cyc;
    d   = n + 4;
    r   = d + 5;
    l   = r + g + 2;
    win = (t < 1) ? 1 : t;
    if (rxv >= rmin) k = (rx_rel > 0) ? rx_rel : 0;
    else             k = win;
    if (k <= win - 1) begin
      e = l + k + 1;
      c = 8'h01;
    end else begin
      e = l + win;
      c = 8'h02;
    end
    for (int i = n + 1; i < e; i++) if (i < MAXC) exp_busy[i] = 1'b1;
    exp_start[n + 2] = 1'b1;
    set_irq_from(e, c);
    clr_irq_from(e + 3);
    pin_rise  = n + pin_off;
    pin_cause = pin_c;
    exp_rises++;
    go             = 1'b1;
    size_fifo_tx   = 8'd4;
    ready_tx       = 1'b1;
    guard_interval = g;
    listen_timeout = t;
    rx_min_bytes   = rmin;
    size_fifo_rx   = 8'd0;
    while (cyc < e + 3) begin
      tick();
      go             = 1'b0;
      guard_interval = 32'd0;
      listen_timeout = 32'd0;
      rx_min_bytes   = 8'd0;
      ready_tx       = !((cyc >= d) && (cyc < r));
      size_fifo_rx   = (cyc >= l + rx_rel) ? rxv : 8'd0;
      irq_ack        = (cyc == e + 2);
    end
    size_fifo_rx = 8'd0;
  endtask

  initial begin : stimulus
    int n, x;
    for (int i = 0; i < MAXC; i++) exp_cause[i] = 8'h00;
    #23 reset_n = 1'b1;
    tick(); tick(); tick();

    // Normal RX cycle: irq 42 cycles after go
    do_cycle(10, 100, 3, 20, 3, 42, 8'h01);
    // Timeout: irq 100 cycles after LISTEN entry (go+21)
    do_cycle(10, 100, 3, 0, 0, 121, 8'h02);
    // Guard blanking: RX already full during GUARD, irq on LISTEN cycle 0
    do_cycle(10, 100, 3, -11, 10, 22, 8'h01);

    // abort while IDLE does nothing
    abort = 1'b1;
    tick();
    abort = 1'b0;
    tick();

    // Empty TX FIFO held 50 cycles, then abort
    n = cyc;
    for (int i = n + 1; i <= n + 51; i++) exp_busy[i] = 1'b1;
    set_irq_from(n + 52, 8'h03);
    pin_rise  = n + 52;
    pin_cause = 8'h03;
    exp_rises++;
    go           = 1'b1;
    size_fifo_tx = 8'd0;
    ready_tx     = 1'b1;
    while (cyc < n + 53) begin
      tick();
      go    = 1'b0;
      abort = (cyc == n + 51);
    end
    abort = 1'b0;

    // go while irq pending is ignored; ack, then a new cycle starts
    x = cyc;
    clr_irq_from(x + 3);
    go = 1'b1;
    tick();
    go = 1'b0;
    tick();
    irq_ack = 1'b1;
    tick();
    irq_ack = 1'b0;
    tick();
    do_cycle(2, 5, 3, 0, 0, 18, 8'h02);

    // Reset asserted mid-cycle during GUARD
    n = cyc;
    for (int i = n + 1; i <= n + 12; i++) exp_busy[i] = 1'b1;
    exp_start[n + 2] = 1'b1;
    clear_from(n + 13);
    go             = 1'b1;
    size_fifo_tx   = 8'd4;
    ready_tx       = 1'b1;
    guard_interval = 32'd10;
    listen_timeout = 32'd100;
    rx_min_bytes   = 8'd3;
    while (cyc < n + 12) begin
      tick();
      go       = 1'b0;
      ready_tx = !((cyc >= n + 4) && (cyc < n + 9));
    end
    @(negedge clk);
    #2 reset_n = 1'b0;
    tick();
    #2 reset_n = 1'b1;
    tick();
    tick();

    // Recovery after reset: guard 0, RX hits on LISTEN cycle 1
    do_cycle(0, 3, 2, 1, 5, 13, 8'h01);

`ifdef NAVIG_WATCHDOG_EN
    // TX never goes idle again: watchdog fires 2^20 cycles into TX_WAIT
    n = cyc;
    for (int i = n + 1; i < MAXC; i++) exp_busy[i] = 1'b1;
    if (n + 2 < MAXC) exp_start[n + 2] = 1'b1;
    pin_rise  = n + 4 + 1048576;
    pin_cause = 8'h04;
    exp_rises++;
    go           = 1'b1;
    size_fifo_tx = 8'd4;
    ready_tx     = 1'b1;
    tick();
    go = 1'b0;
    tick();
    tick();
    ready_tx = 1'b0;
    while (cyc < n + 1048586) tick();
    irq_ack = 1'b1;
    tick();
    irq_ack = 1'b0;
`endif

    end_req = 1'b1;
    @(negedge clk);
    @(negedge clk);
    #2;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
